// File: rtl/round_pipe.sv
// round_pipe: two-stage rounding pipeline for a (2*NSIG+2)-bit product significand.
// Stage 1 splits the operand into retained/guard/sticky and picks the increment;
// stage 2 adds it and raises the carry-out as overflow. Valid/ready flow control
// lets each stage advance independently, and a saturating counter tallies the
// overflowed results the consumer accepts.
module round_pipe #(
  parameter int NSIG = 7,
  parameter int TAGW = 4,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*NSIG+1:0] in_sig,
  input  logic              in_sign,
  input  logic [1:0]        in_rmode,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NSIG-1:0]   out_sig,
  output logic              out_overflow,
  output logic              out_inexact,
  output logic              out_sign,
  output logic [TAGW-1:0]   out_tag,
  input  logic              cnt_clr,
  output logic [CNTW-1:0]   ovf_count
);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  typedef struct packed {
    logic [NSIG-1:0] r;
    logic            inc;
    logic            inx;
    logic            sgn;
    logic [TAGW-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [NSIG-1:0] sig;
    logic            ovf;
    logic            inx;
    logic            sgn;
    logic [TAGW-1:0] tag;
  } s2_t;

  // vld_q[1] / vld_q[2] are the stage-1 / stage-2 occupancy bits
  logic [2:1]      vld_q;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [CNTW-1:0] cnt_d, cnt_q;
  logic            en1, en2;
  logic [NSIG:0]   sum;
  logic            g, s;

  // the MSB is left to upstream normalisation and plays no part in rounding
  logic unused_msb;
  assign unused_msb = in_sig[2*NSIG+1];

  // A stage may load when it is empty or its content is moving on this cycle
  assign en2      = ~vld_q[2] | out_ready;
  assign en1      = ~vld_q[1] | en2;
  assign in_ready = en1;

  // Stage-1 next state: field split and mode-dependent increment
  always_comb begin
    s1_d     = '0;
    g        = in_sig[NSIG];
    s        = |in_sig[NSIG-1:0];
    s1_d.r   = in_sig[2*NSIG:NSIG+1];
    s1_d.inx = g | s;
    s1_d.sgn = in_sign;
    s1_d.tag = in_tag;
    case (in_rmode)
      RM_RNE:  s1_d.inc = g & (s | s1_d.r[0]);
      RM_RTZ:  s1_d.inc = 1'b0;
      RM_RDN:  s1_d.inc = in_sign & s1_d.inx;
      RM_RUP:  s1_d.inc = ~in_sign & s1_d.inx;
      default: s1_d.inc = 1'b0;
    endcase
  end

  // Stage-2 next state: one-wider add so the carry-out becomes the overflow flag
  always_comb begin
    s2_d     = '0;
    sum      = {1'b0, s1_q.r} + {{NSIG{1'b0}}, s1_q.inc};
    s2_d.sig = sum[NSIG-1:0];
    s2_d.ovf = sum[NSIG];
    s2_d.inx = s1_q.inx;
    s2_d.sgn = s1_q.sgn;
    s2_d.tag = s1_q.tag;
  end

  // Overflow counter next state: clear beats increment, saturate at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (vld_q[2] && out_ready && s2_q.ovf && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  // Pipeline registers and counter; reset flushes everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (en1) begin
        vld_q[1] <= in_valid;
        s1_q     <= s1_d;
      end
      if (en2) begin
        vld_q[2] <= vld_q[1];
        s2_q     <= s2_d;
      end
      cnt_q <= cnt_d;
    end
  end

  assign out_valid    = vld_q[2];
  assign out_sig      = s2_q.sig;
  assign out_overflow = s2_q.ovf;
  assign out_inexact  = s2_q.inx;
  assign out_sign     = s2_q.sgn;
  assign out_tag      = s2_q.tag;
  assign ovf_count    = cnt_q;

endmodule

// File: tb/tb_round_pipe.sv
// Scoreboard bench for round_pipe (NSIG=7, TAGW=4, CNTW=2). Stimulus pushes
// hand-computed expectations on acceptance; a negedge monitor pops and compares
// on every output transfer, and also tracks occupancy, hold-under-stall and
// the overflow counter.
module tb_round_pipe;
  localparam int NSIG = 7;
  localparam int TAGW = 4;
  localparam int CNTW = 2;
  localparam int CMAX = (1 << CNTW) - 1;

  logic              clk, rst, in_valid, in_ready, in_sign, out_valid, out_ready;
  logic [2*NSIG+1:0] in_sig;
  logic [1:0]        in_rmode;
  logic [TAGW-1:0]   in_tag, out_tag;
  logic [NSIG-1:0]   out_sig;
  logic              out_overflow, out_inexact, out_sign, cnt_clr;
  logic [CNTW-1:0]   ovf_count;

  round_pipe #(.NSIG(NSIG), .TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sig(in_sig), .in_sign(in_sign), .in_rmode(in_rmode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sig(out_sig),
    .out_overflow(out_overflow), .out_inexact(out_inexact), .out_sign(out_sign),
    .out_tag(out_tag), .cnt_clr(cnt_clr), .ovf_count(ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sig; logic sign; logic [1:0] mode; logic [3:0] tag;
    logic [6:0] esig; logic eovf; logic einx;
  } vec_t;

  typedef struct {
    logic [6:0] sig; logic ovf; logic inx; logic sgn; logic [3:0] tag;
    int acc; bit lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  bit   chk_lat = 1'b0;
  int   errors = 0, checks = 0, cyc = 0;
  vec_t vecs[11];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] sig, input logic sign, input logic [1:0] mode,
                              input logic [3:0] tag, input logic [6:0] esig,
                              input logic eovf, input logic einx);
    vec_t v;
    v.sig = sig; v.sign = sign; v.mode = mode; v.tag = tag;
    v.esig = esig; v.eovf = eovf; v.einx = einx;
    return v;
  endfunction

  task automatic send(input vec_t v);
    @(posedge clk); #1;
    in_valid = 1'b1; in_sig = v.sig; in_sign = v.sign; in_rmode = v.mode; in_tag = v.tag;
    cur_exp.sig = v.esig; cur_exp.ovf = v.eovf; cur_exp.inx = v.einx;
    cur_exp.sgn = v.sign; cur_exp.tag = v.tag; cur_exp.acc = 0; cur_exp.lat = chk_lat;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (n == 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready got 0 expected 1 (cycle %0d)", cyc);
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
  endtask

  // Monitor: occupancy-derived in_ready, stall hold, scoreboard pop, counter model
  initial begin : monitor
    exp_t       e;
    int         m;
    bit         stall;
    logic [6:0] h_sig;
    logic [3:0] h_tag;
    logic       h_ovf, h_inx;
    m = 0; stall = 1'b0; h_sig = '0; h_tag = '0; h_ovf = 1'b0; h_inx = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("ovf_count", {30'd0, ovf_count}, m);
      if (rst) begin
        sb.delete();
        stall = 1'b0;
        m = 0;
      end else begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, !(sb.size() == 2 && !out_ready)});
        if (stall) begin
          chk("hold_valid", {31'd0, out_valid}, 1);
          chk("hold_sig", {25'd0, out_sig}, {25'd0, h_sig});
          chk("hold_tag", {28'd0, out_tag}, {28'd0, h_tag});
          chk("hold_flags", {30'd0, out_overflow, out_inexact}, {30'd0, h_ovf, h_inx});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got tag 0x%0h expected no result", out_tag);
          end else begin
            e = sb.pop_front();
            chk("out_sig", {25'd0, out_sig}, {25'd0, e.sig});
            chk("out_overflow", {31'd0, out_overflow}, {31'd0, e.ovf});
            chk("out_inexact", {31'd0, out_inexact}, {31'd0, e.inx});
            chk("out_sign", {31'd0, out_sign}, {31'd0, e.sgn});
            chk("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
            if (e.lat) chk("latency", cyc - e.acc, 2);
          end
        end
        stall = out_valid && !out_ready;
        h_sig = out_sig; h_tag = out_tag; h_ovf = out_overflow; h_inx = out_inexact;
        if (cnt_clr) m = 0;
        else if (out_valid && out_ready && out_overflow && m < CMAX) m++;
        if (in_valid && in_ready) begin
          e = cur_exp;
          e.acc = cyc;
          sb.push_back(e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation got no end expected finish");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; in_valid = 1'b0; in_sig = '0; in_sign = 1'b0; in_rmode = 2'b00;
    in_tag = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    cur_exp = '{default: 0};
    //            sig       sgn  mode   tag  esig        ovf  inx
    vecs[0]  = mk(16'h01C0, 0, 2'b00, 4'd0, 7'b0000010, 0, 1);
    vecs[1]  = mk(16'h0280, 0, 2'b00, 4'd1, 7'b0000010, 0, 1);
    vecs[2]  = mk(16'h0380, 0, 2'b00, 4'd2, 7'b0000100, 0, 1);
    vecs[3]  = mk(16'h0000, 0, 2'b00, 4'd3, 7'b0000000, 0, 0);
    vecs[4]  = mk(16'hFF80, 0, 2'b00, 4'd4, 7'b0000000, 1, 1);
    vecs[5]  = mk(16'hFEC0, 0, 2'b00, 4'd5, 7'b1111111, 0, 1);
    vecs[6]  = mk(16'h0281, 1, 2'b10, 4'd6, 7'b0000011, 0, 1);
    vecs[7]  = mk(16'h0281, 1, 2'b11, 4'd7, 7'b0000010, 0, 1);
    vecs[8]  = mk(16'h0281, 0, 2'b01, 4'd8, 7'b0000010, 0, 1);
    vecs[9]  = mk(16'h0281, 0, 2'b11, 4'd9, 7'b0000011, 0, 1);
    vecs[10] = mk(16'h8180, 1, 2'b00, 4'hA, 7'b0000010, 0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_sig", {25'd0, out_sig}, 0);
    chk("rst_flags", {29'd0, out_overflow, out_inexact, out_sign}, 0);
    chk("rst_out_tag", {28'd0, out_tag}, 0);
    chk("rst_ovf_count", {30'd0, ovf_count}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Rounding vectors back to back, mode changing per operand
    chk_lat = 1'b1;
    for (int i = 0; i < 11; i++) send(vecs[i]);
    idle();
    drain();

    // Saturating counter: clear, then five overflowing results
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(mk(16'hFF80, 0, 2'b00, 4'(i), 7'd0, 1, 1));
    idle();
    drain();
    @(negedge clk);
    chk("cnt_saturated", {30'd0, ovf_count}, CMAX);

    // Clear coinciding with an overflow transfer
    chk_lat = 1'b0;
    @(posedge clk); #1 out_ready = 1'b0;
    send(mk(16'hFF80, 1, 2'b00, 4'hC, 7'd0, 1, 1));
    idle();
    for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
    @(posedge clk); #1 begin out_ready = 1'b1; cnt_clr = 1'b1; end
    @(posedge clk); #1 cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_wins", {30'd0, ovf_count}, 0);
    drain();

    // Backpressure: four back-to-back operands, consumer stalls three cycles
    fork
      begin
        send(mk(16'h01C0, 0, 2'b00, 4'd0, 7'b0000010, 0, 1));
        send(mk(16'h0380, 1, 2'b00, 4'd1, 7'b0000100, 0, 1));
        send(mk(16'hFF80, 0, 2'b01, 4'd2, 7'b1111111, 0, 1));
        send(mk(16'h0000, 1, 2'b10, 4'd3, 7'b0000000, 0, 0));
      end
      begin
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle();
    drain();

    // Reset with two operands in flight; counter first made nonzero
    send(mk(16'hFF80, 0, 2'b00, 4'hE, 7'd0, 1, 1));
    idle();
    drain();
    @(posedge clk); #1 out_ready = 1'b0;
    send(mk(16'h0380, 0, 2'b00, 4'h5, 7'b0000100, 0, 1));
    send(mk(16'hFF80, 0, 2'b00, 4'h6, 7'd0, 1, 1));
    idle();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_flush_valid", {31'd0, out_valid}, 0);
    chk("rst_flush_cnt", {30'd0, ovf_count}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/round_pipe.md
ROUND_PIPE -- requirements
Module: round_pipe

Interface
REQ-001 Parameter NSIG, default 7, retained significand width.
REQ-002 Parameter TAGW, default 4, width of the sideband tag carried with each operand.
REQ-003 Parameter CNTW, default 8, width of the overflow event counter.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; no other clocks or resets.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  operand present.
REQ-008 in_ready  out  1  block accepts operand this cycle.
REQ-009 in_sig  in  2*NSIG+2  unrounded product significand.
REQ-010 in_sign  in  1  sign of the value; 1 = negative.
REQ-011 in_rmode  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf).
REQ-012 in_tag  in  TAGW  sideband, passed through unchanged.
REQ-013 out_valid  out  1  result present.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 out_sig  out  NSIG  rounded significand.
REQ-016 out_overflow  out  1  rounding carried out of NSIG bits.
REQ-017 out_inexact  out  1  discarded bits were nonzero.
REQ-018 out_sign  out  1  registered copy of in_sign.
REQ-019 out_tag  out  TAGW  registered copy of in_tag.
REQ-020 cnt_clr  in  1  synchronous clear of ovf_count.
REQ-021 ovf_count  out  CNTW  saturating count of overflowed results delivered.

Function
REQ-022 Field split: retained R = in_sig[2*NSIG:NSIG+1]; guard G = in_sig[NSIG]; sticky S = OR of in_sig[NSIG-1:0]; in_sig[2*NSIG+1] ignored (normalisation is upstream).
REQ-023 inexact = G | S.
REQ-024 Increment: RNE inc = G & (S | R[0]); RTZ inc = 0; RDN inc = in_sign & inexact; RUP inc = ~in_sign & inexact.
REQ-025 Sum = R + inc computed NSIG+1 bits wide; out_sig = Sum[NSIG-1:0]; out_overflow = Sum[NSIG] (all-ones R with inc=1 gives out_sig 0, out_overflow 1).
REQ-026 Two-stage pipeline: stage 1 registers R, inc, inexact, sign, tag; stage 2 registers the sum and flags; latency exactly 2 cycles from accepted input to out_valid when unstalled.
REQ-027 Enables: en2 = ~v2 | out_ready; en1 = ~v1 | en2; in_ready = en1 (combinational from out_ready, no registered stage).
REQ-028 On en1, v1 <= in_valid and stage-1 data loads; on en2, v2 <= v1 and stage-2 data loads; out_valid = v2.
REQ-029 Throughput one result per cycle while out_ready=1; when out_ready=0, out_* hold stable and in_ready falls once both stages are full.
REQ-030 No operand dropped, duplicated or reordered under any out_ready pattern.
REQ-031 ovf_count increments by 1 on a cycle with out_valid & out_ready & out_overflow; holds at 2^CNTW-1 (no wrap).
REQ-032 cnt_clr=1 sets ovf_count to 0 next cycle, overriding a simultaneous increment.
REQ-033 in_rmode is sampled with the operand; mode changes between operands take effect per operand with no bubble.

Reset
REQ-034 rst=1 SHALL clear v1, v2, ovf_count, out_sig, out_overflow, out_inexact, out_sign, out_tag to 0; in_ready reads 1 the cycle after reset deasserts.
REQ-035 Reset mid-operation discards all in-flight operands; no result from before reset appears after it.
REQ-036 rst has priority over cnt_clr and over all handshakes.

Verification (NSIG=7)
REQ-037 RNE, out_ready=1: in_sig 16'h01C0 -> out_sig 7'b0000010, inexact 1; 16'h0280 -> 7'b0000010 (tie, even kept); 16'h0380 -> 7'b0000100; 16'h0000 -> 0, inexact 0; each out_valid exactly 2 cycles after acceptance.
REQ-038 Overflow: 16'hFF80 RNE -> out_sig 0, out_overflow 1, ovf_count 0->1 on transfer; 16'hFEC0 -> 7'b1111111, overflow 0.
REQ-039 Modes on 16'h0281: sign=1 RDN -> 7'b0000011; sign=1 RUP -> 7'b0000010; RTZ -> 7'b0000010; sign=0 RUP -> 7'b0000011; all inexact 1.
REQ-040 Backpressure: 4 back-to-back operands tagged 0..3, out_ready low 3 cycles -> in_ready low while both stages full, outputs stable, tags emerge 0,1,2,3 exactly once.
REQ-041 Counter: CNTW=2, 5 overflowing results -> ovf_count 1,2,3,3,3; cnt_clr asserted with an overflow transfer -> 0.
REQ-042 Reset with two operands in flight -> out_valid 0 next cycle, no stale result afterwards, ovf_count 0.
